mmu_xlate_requester: RTL and testbench
======================================

Name: mmu_xlate_requester

Overview:
- Initiator side of the simple_mmu request/response interface.
- Accepts one CPU load/store at a time carrying a virtual address and issues it to simple_mmu. It then forwards the translated physical address to the cache controller, or reports a fault.
- Keeps saturating hit/miss/fault counters and a response watchdog.

Parameters:
- ADDR_WIDTH, 32: VA/PA width; equals `ADDR_WIDTH.
- TIMEOUT_CYCLES, 64: maximum WAIT_RESP cycles before a timeout fault; must exceed worst-case MMU latency.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU access request.
- cpu_req_va  in  ADDR_WIDTH  virtual address.
- cpu_req_we  in  1  1=store, 0=load.
- cpu_req_ready  out  1  high only in IDLE.
- mmu_req_valid  out  1  to simple_mmu.
- mmu_req_va  out  ADDR_WIDTH  registered VA.
- mmu_req_ready  in  1  from simple_mmu.
- mmu_resp_valid  in  1  from simple_mmu.
- mmu_resp_pa  in  ADDR_WIDTH  translated PA.
- mmu_resp_status  in  2  00=HIT, 01=MISS, 10=FAULT, 11=treated as FAULT.
- mmu_resp_ready  out  1  to simple_mmu.
- cache_req_valid  out  1  translated access to the cache controller.
- cache_req_pa  out  ADDR_WIDTH  physical address.
- cache_req_we  out  1  copied from cpu_req_we.
- cache_req_ready  in  1  from the cache controller.
- fault_valid  out  1  fault report.
- fault_va  out  ADDR_WIDTH  faulting VA.
- fault_code  out  2  01=page fault, 10=timeout, 11=reserved status.
- fault_ack  in  1  consumer accepts the fault.
- hit_cnt, miss_cnt, fault_cnt  out  CNT_WIDTH each  saturating statistics counters.

Behaviour:
- Reset (rst high at a clk edge):
  - State=IDLE.
  - All valid outputs 0; mmu_resp_ready=0.
  - Address/data registers, fault_code, counters and watchdog cleared to 0.
  - Reset mid-transaction abandons the transaction silently; no fault is reported and no counter is updated.
- A handshake completes on any clk edge where valid and ready are both high.
- IDLE:
  - cpu_req_ready=1; mmu_resp_ready=1, so any stale response is accepted and dropped.
  - On CPU handshake: latch va/we and go to REQ. mmu_req_valid rises the next cycle.
- REQ:
  - mmu_req_valid=1, held stable with mmu_req_va until mmu_req_ready.
  - mmu_resp_ready=1; responses arriving here are stale and are dropped.
  - On handshake: go to WAIT_RESP and clear the watchdog.
- WAIT_RESP:
  - mmu_resp_ready=1; watchdog increments every cycle.
  - On response handshake with status HIT or MISS: latch the PA, increment hit_cnt or miss_cnt, go to ISSUE.
  - On status 10: fault_code=01, increment fault_cnt, go to FAULT.
  - On status 11: fault_code=11, increment fault_cnt, go to FAULT.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no response: fault_code=10, increment fault_cnt, go to FAULT.
  - A response arriving in the same cycle as the timeout wins; the timeout is ignored.
- ISSUE:
  - cache_req_valid=1 with pa/we stable until cache_req_ready, then go to IDLE.
  - mmu_resp_ready=0.
- FAULT:
  - fault_valid=1 with fault_va=latched VA until fault_ack, then go to IDLE.
  - mmu_resp_ready=0.
- Latency, HIT path with all readies high:
  - CPU handshake at cycle N; mmu_req_valid at N+1.
  - MMU response handshake at cycle M; cache_req_valid at M+1.
  - cpu_req_ready returns in the cycle after the cache handshake.
- Only one transaction is outstanding at a time; there is no queue.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- All outputs are registered or decoded from state only; no combinational path from input to output.

Test Plan:
- Reset, then issue VA 0x00000123 (mock maps VPN0->PFN10):
  - mmu_req_va=0x00000123; response status MISS.
  - cache_req_pa=0x0000A123; miss_cnt=1.
- Issue VA 0x00000ABC right after:
  - status HIT; cache_req_pa=0x0000AABC; hit_cnt=1.
  - Latency is exactly as specified above.
- Issue VA 0x00004040 (VPN4, unmapped):
  - fault_valid=1, fault_va=0x00004040, fault_code=01, fault_cnt=1; no cache_req_valid.
  - Hold fault_ack low 5 cycles: fault_valid stays high and cpu_req_ready stays 0.
- MMU model that never responds:
  - After 64 WAIT_RESP cycles, fault_code=10.
  - A late response then delivered in IDLE is dropped; no cache request and no counter change.
- Stall mmu_req_ready low 3 cycles and cache_req_ready low 4 cycles on VA 0x00001010:
  - mmu_req_va and cache_req_pa=0x0000B010 stay stable while stalled; exactly one transaction completes.
- Assert rst while in WAIT_RESP:
  - Next cycle every output is at its reset value; counters are 0; a following VA 0x00002020 completes normally with PA 0x0000C020.

Source files
------------

// File: rtl/mmu_xlate_requester_if.sv
// rtl/mmu_xlate_requester_if.sv - CPU/MMU/cache/fault signal bundle for mmu_xlate_requester
//
// Groups every non-clock/reset port of the requester.
//   master : the requester side (drives *_req_valid, mmu_resp_ready, fault report, counters)
//   slave  : the environment side (CPU, simple_mmu, cache controller, fault consumer)
interface mmu_xlate_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // CPU request
    logic                  cpu_req_valid;
    logic [ADDR_WIDTH-1:0] cpu_req_va;
    logic                  cpu_req_we;
    logic                  cpu_req_ready;
    // simple_mmu request/response
    logic                  mmu_req_valid;
    logic [ADDR_WIDTH-1:0] mmu_req_va;
    logic                  mmu_req_ready;
    logic                  mmu_resp_valid;
    logic [ADDR_WIDTH-1:0] mmu_resp_pa;
    logic [1:0]            mmu_resp_status;
    logic                  mmu_resp_ready;
    // cache controller request
    logic                  cache_req_valid;
    logic [ADDR_WIDTH-1:0] cache_req_pa;
    logic                  cache_req_we;
    logic                  cache_req_ready;
    // fault report
    logic                  fault_valid;
    logic [ADDR_WIDTH-1:0] fault_va;
    logic [1:0]            fault_code;
    logic                  fault_ack;
    // statistics
    logic [CNT_WIDTH-1:0]  hit_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;
    logic [CNT_WIDTH-1:0]  fault_cnt;

    modport master (
        input  cpu_req_valid, cpu_req_va, cpu_req_we,
        output cpu_req_ready,
        output mmu_req_valid, mmu_req_va,
        input  mmu_req_ready,
        input  mmu_resp_valid, mmu_resp_pa, mmu_resp_status,
        output mmu_resp_ready,
        output cache_req_valid, cache_req_pa, cache_req_we,
        input  cache_req_ready,
        output fault_valid, fault_va, fault_code,
        input  fault_ack,
        output hit_cnt, miss_cnt, fault_cnt
    );

    modport slave (
        output cpu_req_valid, cpu_req_va, cpu_req_we,
        input  cpu_req_ready,
        input  mmu_req_valid, mmu_req_va,
        output mmu_req_ready,
        output mmu_resp_valid, mmu_resp_pa, mmu_resp_status,
        input  mmu_resp_ready,
        input  cache_req_valid, cache_req_pa, cache_req_we,
        output cache_req_ready,
        input  fault_valid, fault_va, fault_code,
        output fault_ack,
        input  hit_cnt, miss_cnt, fault_cnt
    );
endinterface

// File: rtl/mmu_xlate_requester.sv
// rtl/mmu_xlate_requester.sv - single-outstanding VA->PA translation requester for simple_mmu
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mmu_xlate_requester_if.master (CPU request in, MMU request/response,
//          cache request out, fault report, saturating hit/miss/fault counters)
//
// One CPU access is accepted in IDLE, sent to the MMU, and then either forwarded
// to the cache (HIT/MISS) or reported as a fault (MMU fault, reserved status, or
// response watchdog timeout). All outputs come from registers or state decode.
module mmu_xlate_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mmu_xlate_requester_if.master bus
);

    localparam int                  WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_ISSUE,
        S_FAULT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] va_q, va_d;
    logic [ADDR_WIDTH-1:0] pa_q, pa_d;
    logic                  we_q, we_d;
    logic [1:0]            code_q, code_d;
    logic [WD_WIDTH-1:0]   wd_q, wd_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  miss_q, miss_d;
    logic [CNT_WIDTH-1:0]  fault_q, fault_d;
    logic                  resp_rdy_q, resp_rdy_d;

    logic cpu_hs;
    logic req_hs;
    logic resp_hs;
    logic timeout;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Responses outside WAIT_RESP are accepted (resp_ready high) but never acted on.
    assign cpu_hs  = (state_q == S_IDLE) && bus.cpu_req_valid;
    assign req_hs  = (state_q == S_REQ) && bus.mmu_req_ready;
    assign resp_hs = (state_q == S_WAIT_RESP) && bus.mmu_resp_valid && resp_rdy_q;
    // A response in the final watchdog cycle takes priority over the timeout.
    assign timeout = (state_q == S_WAIT_RESP) && (wd_q == WD_LAST) && !resp_hs;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cpu_hs) state_d = S_REQ;
            S_REQ:       if (req_hs) state_d = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (resp_hs) begin
                    state_d = bus.mmu_resp_status[1] ? S_FAULT : S_ISSUE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_ISSUE:     if (bus.cache_req_ready) state_d = S_IDLE;
            S_FAULT:     if (bus.fault_ack) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        bus.cpu_req_ready   = 1'b0;
        bus.mmu_req_valid   = 1'b0;
        bus.cache_req_valid = 1'b0;
        bus.fault_valid     = 1'b0;
        case (state_q)
            S_IDLE:  bus.cpu_req_ready   = 1'b1;
            S_REQ:   bus.mmu_req_valid   = 1'b1;
            S_ISSUE: bus.cache_req_valid = 1'b1;
            S_FAULT: bus.fault_valid     = 1'b1;
            default: ;
        endcase
    end

    assign bus.mmu_req_va     = va_q;
    assign bus.mmu_resp_ready = resp_rdy_q;
    assign bus.cache_req_pa   = pa_q;
    assign bus.cache_req_we   = we_q;
    assign bus.fault_va       = va_q;
    assign bus.fault_code     = code_q;
    assign bus.hit_cnt        = hit_q;
    assign bus.miss_cnt       = miss_q;
    assign bus.fault_cnt      = fault_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        va_d    = va_q;
        we_d    = we_q;
        pa_d    = pa_q;
        code_d  = code_q;
        wd_d    = wd_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        fault_d = fault_q;

        if (cpu_hs) begin
            va_d = bus.cpu_req_va;
            we_d = bus.cpu_req_we;
        end

        if (req_hs) begin
            wd_d = '0;
        end else if (state_q == S_WAIT_RESP) begin
            wd_d = wd_q + 1'b1;
        end

        if (resp_hs) begin
            case (bus.mmu_resp_status)
                2'b00: begin
                    pa_d  = bus.mmu_resp_pa;
                    hit_d = sat_inc(hit_q);
                end
                2'b01: begin
                    pa_d   = bus.mmu_resp_pa;
                    miss_d = sat_inc(miss_q);
                end
                2'b10: begin
                    code_d  = 2'b01;
                    fault_d = sat_inc(fault_q);
                end
                default: begin
                    code_d  = 2'b11;
                    fault_d = sat_inc(fault_q);
                end
            endcase
        end else if (timeout) begin
            code_d  = 2'b10;
            fault_d = sat_inc(fault_q);
        end

        // Registered so it is low while in reset, then follows the state.
        resp_rdy_d = (state_d == S_IDLE) || (state_d == S_REQ) || (state_d == S_WAIT_RESP);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q       <= '0;
            we_q       <= 1'b0;
            pa_q       <= '0;
            code_q     <= 2'b00;
            wd_q       <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            fault_q    <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            va_q       <= va_d;
            we_q       <= we_d;
            pa_q       <= pa_d;
            code_q     <= code_d;
            wd_q       <= wd_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            fault_q    <= fault_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

endmodule

// File: tb/tb_mmu_xlate_requester.sv
// tb/tb_mmu_xlate_requester.sv - self-checking bench for mmu_xlate_requester
module tb_mmu_xlate_requester;

    localparam int AW   = 32;
    localparam int CW   = 4;
    localparam int TMO  = 64;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_RESP   = 0;
    localparam int M_NORESP = 1;
    localparam int M_RESET  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mmu_xlate_requester_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    mmu_xlate_requester #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state: counters and which pages the mock TLB has already seen
    int hit_m   = 0;
    int miss_m  = 0;
    int fault_m = 0;
    bit seen[8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // mock page table: VPN -> PFN; VPN 4 and 7 unmapped
    function automatic bit lookup(input logic [31:0] va, output logic [31:0] pa);
        logic [19:0] pfn;
        bit ok;
        ok = 1'b1;
        case (va[31:12])
            20'd0:   pfn = 20'hA;
            20'd1:   pfn = 20'hB;
            20'd2:   pfn = 20'hC;
            20'd3:   pfn = 20'hD;
            20'd5:   pfn = 20'hE;
            20'd6:   pfn = 20'hF;
            default: begin pfn = 20'h0; ok = 1'b0; end
        endcase
        pa = {pfn, va[11:0]};
        return ok;
    endfunction

    task automatic check_counters(input string tag);
        check_eq({tag, "_hit_cnt"},   64'(bus.hit_cnt),   64'(hit_m));
        check_eq({tag, "_miss_cnt"},  64'(bus.miss_cnt),  64'(miss_m));
        check_eq({tag, "_fault_cnt"}, 64'(bus.fault_cnt), 64'(fault_m));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cpu_rdy"},     64'(bus.cpu_req_ready),   64'd1);
        check_eq({tag, "_mmu_valid"},   64'(bus.mmu_req_valid),   64'd0);
        check_eq({tag, "_mmu_va"},      64'(bus.mmu_req_va),      64'd0);
        check_eq({tag, "_resp_rdy"},    64'(bus.mmu_resp_ready),  64'd0);
        check_eq({tag, "_cache_valid"}, 64'(bus.cache_req_valid), 64'd0);
        check_eq({tag, "_cache_pa"},    64'(bus.cache_req_pa),    64'd0);
        check_eq({tag, "_cache_we"},    64'(bus.cache_req_we),    64'd0);
        check_eq({tag, "_fault_valid"}, 64'(bus.fault_valid),     64'd0);
        check_eq({tag, "_fault_va"},    64'(bus.fault_va),        64'd0);
        check_eq({tag, "_fault_code"},  64'(bus.fault_code),      64'd0);
        check_counters(tag);
    endtask

    // One full transaction, driven and sampled on negedges.
    task automatic run_txn(input logic [31:0] va, input logic we, input int req_stall,
                           input int resp_lat, input int mode, input bit use11,
                           input int cache_stall, input int ack_stall);
        logic [31:0] pa_exp;
        bit          mapped;
        logic [1:0]  st;
        logic [1:0]  code_exp;
        bit          early;

        mapped = lookup(va, pa_exp);
        if (mapped) st = seen[va[14:12]] ? 2'b00 : 2'b01;
        else        st = use11 ? 2'b11 : 2'b10;

        check_eq("idle_cpu_rdy", 64'(bus.cpu_req_ready), 64'd1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_va    = va;
        bus.cpu_req_we    = we;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_va    = $urandom;
        bus.cpu_req_we    = 1'($urandom);
        check_eq("req_valid_n1", 64'(bus.mmu_req_valid), 64'd1);
        check_eq("req_va",       64'(bus.mmu_req_va),    64'(va));
        check_eq("busy_cpu_rdy", 64'(bus.cpu_req_ready), 64'd0);

        for (int i = 0; i < req_stall; i++) begin
            // stale response while request is still pending: must be ignored
            bus.mmu_resp_valid  = 1'($urandom);
            bus.mmu_resp_status = 2'($urandom);
            bus.mmu_resp_pa     = $urandom;
            @(negedge clk);
            bus.mmu_resp_valid = 1'b0;
            check_eq("req_hold_valid", 64'(bus.mmu_req_valid), 64'd1);
            check_eq("req_hold_va",    64'(bus.mmu_req_va),    64'(va));
        end
        bus.mmu_req_ready = 1'b1;
        @(negedge clk);
        bus.mmu_req_ready = 1'b0;
        check_eq("req_drop", 64'(bus.mmu_req_valid), 64'd0);

        if (mode == M_RESET) begin
            repeat (resp_lat) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            hit_m = 0; miss_m = 0; fault_m = 0;
            check_reset_outputs("midrst");
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        if (mode == M_NORESP) begin
            early = 1'b0;
            for (int i = 0; i < TMO; i++) begin
                if (bus.fault_valid || bus.cache_req_valid) early = 1'b1;
                @(negedge clk);
            end
            check_eq("tmo_not_early", 64'(early), 64'd0);
            code_exp = 2'b10;
            fault_m  = sat(fault_m);
        end else begin
            repeat (resp_lat) @(negedge clk);
            bus.mmu_resp_valid  = 1'b1;
            bus.mmu_resp_status = st;
            bus.mmu_resp_pa     = mapped ? pa_exp : $urandom;
            @(negedge clk);
            bus.mmu_resp_valid = 1'b0;
            if (mapped) seen[va[14:12]] = 1'b1;
            code_exp = (st == 2'b11) ? 2'b11 : 2'b01;
            if (st == 2'b00)      hit_m   = sat(hit_m);
            else if (st == 2'b01) miss_m  = sat(miss_m);
            else                  fault_m = sat(fault_m);
        end

        if (mode == M_RESP && !st[1]) begin
            check_eq("issue_valid_m1", 64'(bus.cache_req_valid), 64'd1);
            check_eq("issue_pa",       64'(bus.cache_req_pa),    64'(pa_exp));
            check_eq("issue_we",       64'(bus.cache_req_we),    64'(we));
            check_eq("issue_no_fault", 64'(bus.fault_valid),     64'd0);
            check_eq("issue_resp_rdy", 64'(bus.mmu_resp_ready),  64'd0);
            check_counters("issue");
            for (int i = 0; i < cache_stall; i++) begin
                @(negedge clk);
                check_eq("issue_hold_valid", 64'(bus.cache_req_valid), 64'd1);
                check_eq("issue_hold_pa",    64'(bus.cache_req_pa),    64'(pa_exp));
                check_eq("issue_hold_cpu",   64'(bus.cpu_req_ready),   64'd0);
            end
            bus.cache_req_ready = 1'b1;
            @(negedge clk);
            bus.cache_req_ready = 1'b0;
            check_eq("post_issue_cpu_rdy", 64'(bus.cpu_req_ready),   64'd1);
            check_eq("post_issue_valid",   64'(bus.cache_req_valid), 64'd0);
        end else begin
            check_eq("fault_valid",    64'(bus.fault_valid),     64'd1);
            check_eq("fault_va",       64'(bus.fault_va),        64'(va));
            check_eq("fault_code",     64'(bus.fault_code),      64'(code_exp));
            check_eq("fault_no_cache", 64'(bus.cache_req_valid), 64'd0);
            check_eq("fault_resp_rdy", 64'(bus.mmu_resp_ready),  64'd0);
            check_counters("fault");
            for (int i = 0; i < ack_stall; i++) begin
                @(negedge clk);
                check_eq("fault_hold_valid", 64'(bus.fault_valid),     64'd1);
                check_eq("fault_hold_cpu",   64'(bus.cpu_req_ready),   64'd0);
                check_eq("fault_hold_cache", 64'(bus.cache_req_valid), 64'd0);
            end
            bus.fault_ack = 1'b1;
            @(negedge clk);
            bus.fault_ack = 1'b0;
            check_eq("post_fault_cpu_rdy", 64'(bus.cpu_req_ready), 64'd1);
            check_eq("post_fault_valid",   64'(bus.fault_valid),   64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [31:0] rva;
        int          rmode;

        bus.cpu_req_valid   = 1'b0;
        bus.cpu_req_va      = '0;
        bus.cpu_req_we      = 1'b0;
        bus.mmu_req_ready   = 1'b0;
        bus.mmu_resp_valid  = 1'b0;
        bus.mmu_resp_pa     = '0;
        bus.mmu_resp_status = 2'b00;
        bus.cache_req_ready = 1'b0;
        bus.fault_ack       = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_resp_rdy", 64'(bus.mmu_resp_ready), 64'd1);

        // directed scenarios
        run_txn(32'h0000_0123, 1'b0, 0, 2, M_RESP, 1'b0, 0, 0);   // MISS
        run_txn(32'h0000_0ABC, 1'b1, 0, 0, M_RESP, 1'b0, 0, 0);   // HIT, minimal latency
        run_txn(32'h0000_4040, 1'b0, 0, 1, M_RESP, 1'b0, 0, 5);   // page fault, ack held off
        run_txn(32'h0000_3030, 1'b1, 0, 0, M_NORESP, 1'b0, 0, 1); // watchdog timeout

        // late response in IDLE is swallowed
        bus.mmu_resp_valid  = 1'b1;
        bus.mmu_resp_status = 2'b00;
        bus.mmu_resp_pa     = 32'h1234_5678;
        @(negedge clk);
        bus.mmu_resp_valid = 1'b0;
        @(negedge clk);
        check_eq("late_no_cache", 64'(bus.cache_req_valid), 64'd0);
        check_eq("late_cpu_rdy",  64'(bus.cpu_req_ready),   64'd1);
        check_counters("late");

        run_txn(32'h0000_1010, 1'b1, 3, 2, M_RESP, 1'b0, 4, 0);   // stalls on both sides
        run_txn(32'h0000_5555, 1'b0, 1, 3, M_RESET, 1'b0, 0, 0);  // reset in WAIT_RESP
        run_txn(32'h0000_2020, 1'b0, 0, 1, M_RESP, 1'b0, 0, 0);   // normal after reset
        run_txn(32'h0000_0777, 1'b0, 0, TMO - 1, M_RESP, 1'b0, 1, 0); // response on last watchdog cycle
        run_txn(32'h0000_7001, 1'b1, 0, 0, M_RESP, 1'b1, 0, 0);   // reserved status

        // randomized traffic; enough hits to push the narrow counters into saturation
        for (int n = 0; n < 40; n++) begin
            rva   = {17'd0, 3'($urandom_range(0, 7)), 12'($urandom)};
            rmode = ($urandom_range(0, 9) == 0) ? M_NORESP : M_RESP;
            run_txn(rva, 1'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 6),
                    rmode, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
